// File: rtl/mem_word_initiator.sv
// Word-level initiator for the start/ready memory handshake: a word read becomes four byte
// reads, a word write becomes one word access, and every access is bounded by a timeout.
module mem_word_initiator #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [31:0]              resp_rdata,
  output logic                     rd_start,
  output logic [ADDRESS_WIDTH-1:0] rd_address,
  input  logic                     rd_ready,
  input  logic [7:0]               rd_data,
  output logic                     wr_start,
  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [31:0]              wr_data,
  input  logic                     wr_ready
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    k_q, k_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic [AW-1:0] rd_address_q, rd_address_d;
  logic [AW-1:0] wr_address_q, wr_address_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic in_rd_c, in_wr_c, port_rdy_c, abort_c;

  // Active port selection and timeout abort condition
  assign in_rd_c    = (state_q == RD_ISSUE) || (state_q == RD_WAIT);
  assign in_wr_c    = (state_q == WR_ISSUE) || (state_q == WR_WAIT);
  assign port_rdy_c = in_rd_c ? rd_ready : wr_ready;
  assign abort_c    = (in_rd_c || in_wr_c) && !port_rdy_c && (tmo_q == TMO_LAST);

  assign rd_start   = (state_q == RD_ISSUE) && rd_ready;
  assign wr_start   = (state_q == WR_ISSUE) && wr_ready;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign rd_address = rd_address_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req) state_d = req_we ? WR_ISSUE : RD_ISSUE;
      RD_ISSUE: begin
        if (rd_ready)     state_d = RD_WAIT;
        else if (abort_c) state_d = RESP;
      end
      RD_WAIT: begin
        if (rd_ready)     state_d = (k_q == 2'd3) ? RESP : RD_ISSUE;
        else if (abort_c) state_d = RESP;
      end
      WR_ISSUE: begin
        if (wr_ready)     state_d = WR_WAIT;
        else if (abort_c) state_d = RESP;
      end
      WR_WAIT: begin
        if (wr_ready)     state_d = RESP;
        else if (abort_c) state_d = RESP;
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    addr_d       = addr_q;
    k_d          = k_q;
    tmo_d        = tmo_q;
    resp_rdata_d = resp_rdata_q;
    rd_address_d = rd_address_q;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = abort_c;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d       = req_addr;
          k_d          = 2'd0;
          tmo_d        = '0;
          resp_rdata_d = 32'd0;
          if (req_we) begin
            wr_address_d = req_addr;
            wr_data_d    = req_wdata;
          end else begin
            rd_address_d = req_addr;
          end
        end
      end
      RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT: begin
        tmo_d = (port_rdy_c || abort_c) ? '0 : tmo_q + TW'(1);
        // Byte capture and advance to the next byte address (wraps)
        if (state_q == RD_WAIT && rd_ready) begin
          resp_rdata_d[{k_q, 3'b000} +: 8] = rd_data;
          if (k_q != 2'd3) begin
            k_d          = k_q + 2'd1;
            rd_address_d = addr_q + AW'(k_q) + AW'(1);
          end
        end
      end
      default: tmo_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      k_q          <= 2'd0;
      tmo_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      rd_address_q <= '0;
      wr_address_q <= '0;
      wr_data_q    <= 32'd0;
    end else begin
      addr_q       <= addr_d;
      k_q          <= k_d;
      tmo_q        <= tmo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      rd_address_q <= rd_address_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_mem_word_initiator.sv
// Directed bench for mem_word_initiator with behavioural read/write responders and a
// response scoreboard.
module tb_mem_word_initiator;

  localparam int unsigned AW    = 8;
  localparam int          BOUND = 400;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready, resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          rd_start, rd_ready;
  logic [AW-1:0] rd_address;
  logic [7:0]    rd_data;
  logic          wr_start, wr_ready;
  logic [AW-1:0] wr_address;
  logic [31:0]   wr_data;

  int   n_pass = 0, n_total = 0, n_fail = 0;
  int   n_resp = 0, rd_starts = 0, wr_starts = 0;
  logic stall_rd = 1'b0, zero_dly = 1'b0;
  exp_t sb_q[$];
  logic [7:0] rmem [256];
  logic [7:0] wmem [256];

  always #5 clk = ~clk;

  mem_word_initiator #(.ADDRESS_WIDTH(AW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .rd_start(rd_start), .rd_address(rd_address), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_start(wr_start), .wr_address(wr_address), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  // Read responder: busy for 1+c cycles after a start, c = addr[1:0] unless zero_dly
  logic [1:0]    rd_cnt;
  logic [AW-1:0] rd_lat;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ready <= 1'b1;
      rd_data  <= 8'h00;
      rd_cnt   <= 2'd0;
      rd_lat   <= '0;
      for (int i = 0; i < 256; i++) rmem[i] <= (i == 255) ? 8'h00 : 8'(i);
    end else if (rd_start) begin
      rd_ready  <= 1'b0;
      rd_cnt    <= zero_dly ? 2'd0 : rd_address[1:0];
      rd_lat    <= rd_address;
      rd_starts <= rd_starts + 1;
    end else if (!rd_ready && !stall_rd) begin
      if (rd_cnt == 2'd0) begin
        rd_ready <= 1'b1;
        rd_data  <= rmem[rd_lat];
      end else begin
        rd_cnt <= rd_cnt - 2'd1;
      end
    end
  end

  // Write responder: same timing, stores the word little-endian on completion
  logic [1:0]    wr_cnt;
  logic [AW-1:0] wr_lat;
  logic [31:0]   wr_buf;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ready <= 1'b1;
      wr_cnt   <= 2'd0;
      wr_lat   <= '0;
      wr_buf   <= 32'd0;
      for (int i = 0; i < 256; i++) wmem[i] <= 8'h00;
    end else if (wr_start) begin
      wr_ready  <= 1'b0;
      wr_cnt    <= zero_dly ? 2'd0 : wr_address[1:0];
      wr_lat    <= wr_address;
      wr_buf    <= wr_data;
      wr_starts <= wr_starts + 1;
    end else if (!wr_ready) begin
      if (wr_cnt == 2'd0) begin
        wr_ready             <= 1'b1;
        wmem[wr_lat]         <= wr_buf[7:0];
        wmem[8'(wr_lat + 1)] <= wr_buf[15:8];
        wmem[8'(wr_lat + 2)] <= wr_buf[23:16];
        wmem[8'(wr_lat + 3)] <= wr_buf[31:24];
      end else begin
        wr_cnt <= wr_cnt - 2'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pops the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && resp_valid === 1'b1) begin
        n_resp++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("req_ready_in_resp", 32'(req_ready), 32'd0);
        end
      end
    end
  end

  task automatic check_rst(input string p);
    check({p, "_req_ready"}, 32'(req_ready), 32'd1);
    check({p, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({p, "_resp_err"}, 32'(resp_err), 32'd0);
    check({p, "_resp_rdata"}, resp_rdata, 32'd0);
    check({p, "_rd_start"}, 32'(rd_start), 32'd0);
    check({p, "_rd_address"}, 32'(rd_address), 32'd0);
    check({p, "_wr_start"}, 32'(wr_start), 32'd0);
    check({p, "_wr_address"}, 32'(wr_address), 32'd0);
    check({p, "_wr_data"}, wr_data, 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  // One isolated transaction; latency counted in negedges after the accept edge
  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                     input int exp_rs, input int exp_ws);
    int rs0, ws0, lat;
    @(negedge clk);
    wait_ready();
    req = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    sb_q.push_back({exp_err, exp_rd});
    rs0 = rd_starts;
    ws0 = wr_starts;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (resp_valid !== 1'b1 && lat < BOUND);
    if (resp_valid !== 1'b1) check("resp_wait", 32'(resp_valid), 32'd1);
    else if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
    check("rd_start_count", 32'(rd_starts - rs0), 32'(exp_rs));
    check("wr_start_count", 32'(wr_starts - ws0), 32'(exp_ws));
  endtask

  initial begin
    logic          we_t [3];
    logic [AW-1:0] ad_t [3];
    logic [31:0]   wd_t [3];
    logic [31:0]   ex_t [3];
    int n0, n;
    we_t = '{1'b0, 1'b1, 1'b0};
    ad_t = '{8'h08, 8'h30, 8'h34};
    wd_t = '{32'h0, 32'hCAFEF00D, 32'h0};
    ex_t = '{32'h0B0A0908, 32'h0, 32'h37363534};

    req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_rst("rst");
    reset = 1'b1;

    // Read with per-byte responder delays 0..3
    txn(1'b0, 8'h10, 32'h0, 32'h13121110, 1'b0, 19, 4, 0);
    check("rd_address_last", 32'(rd_address), 32'h13);

    // Word write
    txn(1'b1, 8'h20, 32'hDEADBEEF, 32'h0, 1'b0, 4, 0, 1);
    check("wr_address", 32'(wr_address), 32'h20);
    check("wmem_20", {wmem[8'h23], wmem[8'h22], wmem[8'h21], wmem[8'h20]}, 32'hDEADBEEF);

    // Address wrap; location FF holds 0 after reset
    txn(1'b0, 8'hFE, 32'h0, 32'h010000FE, 1'b0, 19, 4, 0);
    check("rd_address_wrap", 32'(rd_address), 32'h01);

    // Zero-delay read
    zero_dly = 1'b1;
    txn(1'b0, 8'h40, 32'h0, 32'h43424140, 1'b0, 13, 4, 0);

    // Responder stalls forever after first start -> timeout abort
    zero_dly = 1'b0;
    stall_rd = 1'b1;
    txn(1'b0, 8'h50, 32'h0, 32'h0, 1'b1, -1, 1, 0);
    @(negedge clk);
    check("req_ready_after_abort", 32'(req_ready), 32'd1);
    check("resp_valid_one_cycle", 32'(resp_valid), 32'd0);
    stall_rd = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the wait phase of byte 2
    zero_dly = 1'b1;
    @(negedge clk);
    wait_ready();
    req = 1'b1; req_we = 1'b0; req_addr = 8'h60;
    sb_q.push_back({1'b0, 32'h0});
    @(posedge clk);
    #1 req = 1'b0;
    repeat (8) @(negedge clk);
    check("partial_before_reset", resp_rdata, 32'h00006160);
    reset = 1'b0;
    #1;
    check_rst("midrst");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    txn(1'b0, 8'h60, 32'h0, 32'h63626160, 1'b0, 13, 4, 0);

    // req held high: back-to-back transactions, one response per accept
    zero_dly = 1'b0;
    n0 = n_resp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wait_ready();
      req = 1'b1; req_we = we_t[i]; req_addr = ad_t[i]; req_wdata = wd_t[i];
      sb_q.push_back({1'b0, ex_t[i]});
      @(posedge clk);
      #1;
      if (i == 2) req = 1'b0;
    end
    n = 0;
    while (n_resp < n0 + 3 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("b2b_resp_count", 32'(n_resp - n0), 32'd3);
    check("wmem_30", {wmem[8'h33], wmem[8'h32], wmem[8'h31], wmem[8'h30]}, 32'hCAFEF00D);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
